// File: rtl/led_pkg.sv
// Shared encodings for the LED pattern feeder: mode codes, FSM states and the LFSR step.
package led_pkg;

    localparam int unsigned LED_WIDTH = 8;

    localparam logic [1:0] MODE_INTERLEAVE = 2'd0;
    localparam logic [1:0] MODE_FILL       = 2'd1;
    localparam logic [1:0] MODE_CHASE      = 2'd2;
    localparam logic [1:0] MODE_LFSR       = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    // 8-bit Fibonacci LFSR step, taps 8,6,5,4, shifting left with feedback into bit 0
    function automatic logic [7:0] lfsr_next(input logic [7:0] cur);
        return {cur[6:0], cur[7] ^ cur[5] ^ cur[4] ^ cur[3]};
    endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Free-running CLK_DIV prescaler with synchronous clear and a terminal-count tick.
module led_tick_gen #(
    parameter int unsigned CLK_DIV = 25_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    output logic tick_c
);

    localparam int unsigned CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;

    // Count 0..CLK_DIV-1, wrap on terminal count, hold at zero while cleared
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else if (clr || (cnt_q == CNT_MAX)) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign tick_c = (cnt_q == CNT_MAX);

endmodule

// File: rtl/led_pattern_feeder.sv
// Serial-bit and shift-strobe generator for an 8-bit SIPO LED register.
// Optional LFSR pattern on mode 3 is built only when LED_FEEDER_LFSR_EN is defined;
// otherwise mode 3 repeats the interleave pattern.
module led_pattern_feeder
    import led_pkg::*;
#(
    parameter int unsigned WIDTH     = LED_WIDTH,
    parameter int unsigned CLK_DIV   = 25_000_000,
    parameter logic [7:0]  LFSR_SEED = 8'hA5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic [1:0]       mode,
    input  logic             mode_valid,
    output logic             mode_ready,
    input  logic [WIDTH-1:0] q_fb,
    output logic             shift_en,
    output logic             s_in,
    output logic             busy
);

    localparam int unsigned PH_W = $clog2(2 * WIDTH);
    localparam int unsigned CC_W = $clog2(WIDTH);

    state_t           state_q, state_d;
    logic [1:0]       cur_mode_q, cur_mode_d;
    logic [PH_W-1:0]  phase_q, phase_d;
    logic [CC_W-1:0]  clr_cnt_q, clr_cnt_d;
    logic             shift_en_d, s_in_d;
    logic             accept_c, strobe_c, pat_bit_c;
    logic             tick_c, tick_clr_c;
    logic             unused_c;

`ifdef LED_FEEDER_LFSR_EN
    logic [7:0] lfsr_q, lfsr_d;
    assign unused_c = ^q_fb[WIDTH-1:1];
`else
    assign unused_c = ^{q_fb[WIDTH-1:1], LFSR_SEED};
`endif

    // Prescaler only runs while the FSM stays in RUN
    assign tick_clr_c = (state_q != ST_RUN) || (state_d != ST_RUN);

    led_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .clk    (clk),
        .reset  (reset),
        .clr    (tick_clr_c),
        .tick_c (tick_c)
    );

    // State and datapath registers; outputs registered from next-state values
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            cur_mode_q <= MODE_INTERLEAVE;
            phase_q    <= '0;
            clr_cnt_q  <= '0;
            shift_en   <= 1'b0;
            s_in       <= 1'b0;
            busy       <= 1'b0;
            mode_ready <= 1'b1;
`ifdef LED_FEEDER_LFSR_EN
            lfsr_q     <= LFSR_SEED;
`endif
        end else begin
            state_q    <= state_d;
            cur_mode_q <= cur_mode_d;
            phase_q    <= phase_d;
            clr_cnt_q  <= clr_cnt_d;
            shift_en   <= shift_en_d;
            s_in       <= s_in_d;
            busy       <= (state_d == ST_CLEAR);
            mode_ready <= (state_d != ST_CLEAR);
`ifdef LED_FEEDER_LFSR_EN
            lfsr_q     <= lfsr_d;
`endif
        end
    end

    // Next-state, pattern selection and strobe generation
    always_comb begin
        state_d    = state_q;
        cur_mode_d = cur_mode_q;
        phase_d    = phase_q;
        clr_cnt_d  = clr_cnt_q;
        shift_en_d = 1'b0;
        s_in_d     = 1'b0;
        strobe_c   = 1'b0;
        pat_bit_c  = 1'b0;
        accept_c   = mode_valid & mode_ready;
`ifdef LED_FEEDER_LFSR_EN
        lfsr_d     = lfsr_q;
`endif

        case (cur_mode_q)
            MODE_FILL:       pat_bit_c = (phase_q < PH_W'(WIDTH));
            MODE_CHASE:      pat_bit_c = (phase_q == '0);
`ifdef LED_FEEDER_LFSR_EN
            MODE_LFSR:       pat_bit_c = lfsr_q[7];
            MODE_INTERLEAVE: pat_bit_c = ~q_fb[0];
`else
            MODE_INTERLEAVE,
            MODE_LFSR:       pat_bit_c = ~q_fb[0];
`endif
        endcase

        case (state_q)
            ST_IDLE: begin
                if (!accept_c && run) begin
                    state_d = ST_RUN;
                end
            end
            ST_CLEAR: begin
                if (clr_cnt_q == CC_W'(WIDTH - 1)) begin
                    clr_cnt_d = '0;
                    state_d   = run ? ST_RUN : ST_IDLE;
                end else begin
                    clr_cnt_d = clr_cnt_q + CC_W'(1);
                end
            end
            ST_RUN: begin
                if (!accept_c) begin
                    if (!run) begin
                        state_d = ST_IDLE;
                    end else if (tick_c) begin
                        strobe_c = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A mode request restarts the pattern after a full flush
        if (accept_c) begin
            cur_mode_d = mode;
            phase_d    = '0;
            clr_cnt_d  = '0;
            state_d    = ST_CLEAR;
`ifdef LED_FEEDER_LFSR_EN
            lfsr_d     = LFSR_SEED;
`endif
        end

        if (strobe_c) begin
            shift_en_d = 1'b1;
            s_in_d     = pat_bit_c;
            case (cur_mode_q)
                MODE_FILL:  phase_d = (phase_q == PH_W'(2 * WIDTH - 1)) ? '0 : phase_q + PH_W'(1);
                MODE_CHASE: phase_d = (phase_q == PH_W'(WIDTH - 1)) ? '0 : phase_q + PH_W'(1);
                default:    phase_d = phase_q;
            endcase
`ifdef LED_FEEDER_LFSR_EN
            if (cur_mode_q == MODE_LFSR) begin
                lfsr_d = lfsr_next(lfsr_q);
            end
`endif
        end

        if (state_d == ST_CLEAR) begin
            shift_en_d = 1'b1;
            s_in_d     = 1'b0;
        end
    end

endmodule

// File: tb/tb_led_pattern_feeder.sv
// Directed/randomised bench for led_pattern_feeder with a SIPO model on q_fb.
module tb_led_pattern_feeder;

    localparam int unsigned W    = 8;
    localparam int unsigned DIV  = 4;
    localparam logic [7:0]  SEED = 8'hA5;

    logic         clk = 1'b0;
    logic         reset;
    logic         run;
    logic [1:0]   mode;
    logic         mode_valid;
    logic         mode_ready;
    logic [W-1:0] q_fb;
    logic         shift_en;
    logic         s_in;
    logic         busy;

    int checks = 0;
    int errors = 0;

    // Reference state: pattern selected, strobes since mode start, expected register, LFSR
    int unsigned  m_mode;
    int unsigned  m_n;
    logic [W-1:0] m_reg;
    logic [7:0]   m_lfsr;

    led_pattern_feeder #(
        .WIDTH     (W),
        .CLK_DIV   (DIV),
        .LFSR_SEED (SEED)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .run        (run),
        .mode       (mode),
        .mode_valid (mode_valid),
        .mode_ready (mode_ready),
        .q_fb       (q_fb),
        .shift_en   (shift_en),
        .s_in       (s_in),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Downstream SIPO: newest bit enters at q_fb[0]
    always @(posedge clk or negedge reset) begin
        if (!reset)        q_fb <= '0;
        else if (shift_en) q_fb <= {q_fb[W-2:0], s_in};
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset(input int unsigned m);
        m_mode = m;
        m_n    = 0;
        m_reg  = '0;
        m_lfsr = SEED;
    endtask

    function automatic logic model_bit();
        logic b;
        case (m_mode)
            1:       b = ((m_n % (2 * W)) < W);
            2:       b = ((m_n % W) == 0);
`ifdef LED_FEEDER_LFSR_EN
            3:       b = m_lfsr[7];
`endif
            default: b = ~m_reg[0];
        endcase
        return b;
    endfunction

    task automatic model_advance(input logic b);
        logic [7:0] l;
        l      = m_lfsr;
        m_lfsr = {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
        m_reg  = {m_reg[W-2:0], b};
        m_n++;
    endtask

    task automatic expect_quiet(input int n);
        for (int i = 0; i < n; i++) begin
            step();
            check("quiet_shift_en", shift_en, 1'b0);
            check("quiet_s_in", s_in, 1'b0);
        end
    endtask

    task automatic expect_strobe();
        logic b;
        step();
        b = model_bit();
        check("strobe_shift_en", shift_en, 1'b1);
        check("strobe_q_fb", q_fb, m_reg);
        check("strobe_s_in", s_in, b);
        model_advance(b);
    endtask

    task automatic run_strobes(input int n);
        for (int i = 0; i < n; i++) begin
            expect_quiet(DIV - 1);
            expect_strobe();
        end
    endtask

    task automatic clear_cycle();
        step();
        check("clear_busy", busy, 1'b1);
        check("clear_shift_en", shift_en, 1'b1);
        check("clear_s_in", s_in, 1'b0);
        check("clear_mode_ready", mode_ready, 1'b0);
    endtask

    // Request mode m; with hold, keep requesting m2 through the flush
    task automatic do_accept(input logic [1:0] m, input bit hold, input logic [1:0] m2);
        check("accept_ready", mode_ready, 1'b1);
        mode       = m;
        mode_valid = 1'b1;
        clear_cycle();
        if (hold) mode = m2;
        else      mode_valid = 1'b0;
        for (int i = 1; i < W; i++) clear_cycle();
        model_reset(32'(m));
        if (hold) begin
            step();
            check("held_ready", mode_ready, 1'b1);
            check("held_busy", busy, 1'b0);
            check("held_shift_en", shift_en, 1'b0);
            clear_cycle();
            mode_valid = 1'b0;
            for (int i = 1; i < W; i++) clear_cycle();
            model_reset(32'(m2));
        end
    endtask

    initial begin
        logic [7:0] first8;
        int unsigned rm;
        first8     = 8'b1010_0101;
        reset      = 1'b0;
        run        = 1'b0;
        mode       = 2'd0;
        mode_valid = 1'b0;

        // Reset state
        repeat ($urandom_range(3, 6)) step();
        check("rst_shift_en", shift_en, 1'b0);
        check("rst_s_in", s_in, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_mode_ready", mode_ready, 1'b1);

        // Release straight into RUN with the default interleave pattern
        run   = 1'b1;
        reset = 1'b1;
        model_reset(0);
        expect_quiet(1);
        run_strobes(6);

        // Fill/clear accepted mid-prescale; register reaches all-ones then all-zeros
        expect_quiet($urandom_range(0, DIV - 1));
        do_accept(2'd1, 1'b0, 2'd0);
        expect_quiet(1);
        run_strobes(8);
        step();
        check("fill_full", q_fb, 8'hFF);
        expect_quiet(DIV - 2);
        expect_strobe();
        run_strobes(7);
        step();
        check("fill_empty", q_fb, 8'h00);
        expect_quiet(DIV - 2);
        expect_strobe();

        // Request held through a flush is taken on the first ready cycle
        do_accept(2'd0, 1'b1, 2'd2);
        expect_quiet(1);
        run_strobes(3);

        // Pause in chase mode; pattern resumes without restarting
        run = 1'b0;
        expect_quiet(20);
        check("pause_busy", busy, 1'b0);
        run = 1'b1;
        expect_quiet(1);
        run_strobes(12);

        // Accept together with run low: full flush, then idle
        run = 1'b0;
        do_accept(2'd1, 1'b0, 2'd0);
        expect_quiet(10);
        check("idle_after_clear_busy", busy, 1'b0);
        check("idle_after_clear_ready", mode_ready, 1'b1);
        run = 1'b1;
        expect_quiet(1);
        run_strobes(5);

        // Mode 3: LFSR when built in, interleave otherwise
        do_accept(2'd3, 1'b0, 2'd0);
        expect_quiet(1);
        for (int i = 0; i < 8; i++) begin
            run_strobes(1);
`ifdef LED_FEEDER_LFSR_EN
            check("lfsr_first8", s_in, first8[7-i]);
`endif
        end
        run_strobes(255);

        // Random mode sequence with random pauses
        for (int k = 0; k < 4; k++) begin
            rm = $urandom_range(0, 3);
            expect_quiet($urandom_range(0, DIV - 1));
            do_accept(2'(rm), 1'b0, 2'd0);
            expect_quiet(1);
            run_strobes($urandom_range(4, 20));
            run = 1'b0;
            expect_quiet($urandom_range(1, 10));
            run = 1'b1;
            expect_quiet(1);
            run_strobes($urandom_range(2, 6));
        end

        // Reset asserted mid-flush clears outputs immediately
        mode       = 2'd2;
        mode_valid = 1'b1;
        clear_cycle();
        mode_valid = 1'b0;
        clear_cycle();
        clear_cycle();
        #2;
        reset = 1'b0;
        #1;
        check("midclr_rst_shift_en", shift_en, 1'b0);
        check("midclr_rst_s_in", s_in, 1'b0);
        check("midclr_rst_busy", busy, 1'b0);
        check("midclr_rst_ready", mode_ready, 1'b1);
        repeat (3) step();
        reset = 1'b1;
        model_reset(0);
        expect_quiet(1);
        run_strobes(4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
